// File: rtl/video_pkg.sv
// Shared video-object definitions: line length, NUSIZ copy codes, copy offsets
// and the signed motion type used by the missile and ball objects.
package video_pkg;

  localparam int LINE_WIDTH_DEFAULT = 160;

  localparam logic [2:0] COPY_ONE          = 3'd0;
  localparam logic [2:0] COPY_TWO_CLOSE    = 3'd1;
  localparam logic [2:0] COPY_TWO_MED      = 3'd2;
  localparam logic [2:0] COPY_THREE_CLOSE  = 3'd3;
  localparam logic [2:0] COPY_TWO_WIDE     = 3'd4;
  localparam logic [2:0] COPY_DOUBLE_SIZE  = 3'd5;
  localparam logic [2:0] COPY_THREE_MED    = 3'd6;
  localparam logic [2:0] COPY_QUAD_SIZE    = 3'd7;

  localparam int unsigned OFFSET_CLOSE = 32'd16;
  localparam int unsigned OFFSET_MED   = 32'd32;
  localparam int unsigned OFFSET_WIDE  = 32'd64;

  typedef logic signed [3:0] motion_t;

  // True when pos is the left edge of one of the copies selected by the code.
  function automatic logic copy_start(input logic [2:0] copies, input int unsigned pos);
    logic hit;
    hit = (pos == 32'd0);
    case (copies)
      COPY_TWO_CLOSE:   hit = hit || (pos == OFFSET_CLOSE);
      COPY_TWO_MED:     hit = hit || (pos == OFFSET_MED);
      COPY_THREE_CLOSE: hit = hit || (pos == OFFSET_CLOSE) || (pos == OFFSET_MED);
      COPY_TWO_WIDE:    hit = hit || (pos == OFFSET_WIDE);
      COPY_THREE_MED:   hit = hit || (pos == OFFSET_MED) || (pos == OFFSET_WIDE);
      default:          hit = hit;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/missile_unit_if.sv
// Control/observation bundle of the missile object. vdel/vdel_load exist only
// when MISSILE_VDEL_EN is defined.
interface missile_unit_if #(
    parameter int POS_BITS  = 8,
    parameter int SIZE_BITS = 2
);
    import video_pkg::*;

    // No valid/ready pair: every control input is a level or a one-clk pulse
    // sampled on each posedge; value/position are registered and always valid.
    logic                 pixel_tick;
    logic                 strobe;
    logic                 hmove;
    motion_t              motion;
    logic [SIZE_BITS-1:0] size;
    logic [2:0]           copies;
    logic                 enable;
    logic                 value;
    logic [POS_BITS-1:0]  position;
`ifdef MISSILE_VDEL_EN
    logic                 vdel;
    logic                 vdel_load;
`endif

    modport master (
        output pixel_tick, strobe, hmove, motion, size, copies, enable,
`ifdef MISSILE_VDEL_EN
        output vdel, vdel_load,
`endif
        input  value, position
    );

    modport slave (
        input  pixel_tick, strobe, hmove, motion, size, copies, enable,
`ifdef MISSILE_VDEL_EN
        input  vdel, vdel_load,
`endif
        output value, position
    );

endinterface

// File: rtl/missile_width_counter.sv
// Draw-width counter: loads (1<<size)-1 on start, counts down per pixel tick
// and drops active after the last pixel. Shared by missile and ball objects.
module missile_width_counter #(
    parameter int SIZE_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 start,
    input  logic [SIZE_BITS-1:0] size,
    output logic                 active_next
);
    localparam int CNT_BITS = (1 << SIZE_BITS) - 1;

    logic                active;
    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    // A start always reloads, even mid-draw: overlapping copies restart, never merge.
    always_comb begin
        active_next = active;
        cnt_d       = cnt_q;
        if (start) begin
            active_next = 1'b1;
            cnt_d       = CNT_BITS'((32'd1 << size) - 32'd1);
        end else if (tick && active) begin
            if (cnt_q == '0) active_next = 1'b0;
            else             cnt_d       = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active <= 1'b0;
            cnt_q  <= '0;
        end else begin
            active <= active_next;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/missile_unit.sv
// TIA-style missile: wrapping position counter, NUSIZ copies, HMOVE nudge and
// enable gating. Define MISSILE_VDEL_EN for the vertical-delay enable shadow.
module missile_unit
    import video_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT,
    parameter int POS_BITS   = 8,
    parameter int SIZE_BITS  = 2
) (
    input  logic           clk,
    input  logic           reset_n,
    missile_unit_if.slave  bus
);
    localparam logic signed [POS_BITS:0] LINE_S = (POS_BITS+1)'(LINE_WIDTH);

    logic [POS_BITS-1:0]      position_q;
    logic                     skip_zero;
    logic                     value_q;
    logic                     start;
    logic                     active_next;
    logic                     enable_eff;
    logic signed [POS_BITS:0] motion_ext;
    logic signed [POS_BITS:0] moved;
    logic signed [POS_BITS:0] moved_wrap;
    logic [POS_BITS-1:0]      inc_pos;

    // A strobe already drew the position-0 copy, so the copy-0 start on the
    // first tick after it (position still 0) is suppressed.
    assign start = bus.strobe |
                   (bus.pixel_tick & ~skip_zero & copy_start(bus.copies, 32'(position_q)));

    assign motion_ext = {{(POS_BITS-3){bus.motion[3]}}, bus.motion};
    assign moved      = $signed({1'b0, position_q}) - motion_ext;
    assign inc_pos    = (position_q == POS_BITS'(LINE_WIDTH - 1)) ? '0 : position_q + 1'b1;

    always_comb begin
        moved_wrap = moved;
        if (moved[POS_BITS])      moved_wrap = moved + LINE_S;
        else if (moved >= LINE_S) moved_wrap = moved - LINE_S;
    end

`ifdef MISSILE_VDEL_EN
    logic enable_shadow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)           enable_shadow <= 1'b0;
        else if (bus.vdel_load) enable_shadow <= bus.enable;
    end

    assign enable_eff = bus.vdel ? enable_shadow : bus.enable;
`else
    assign enable_eff = bus.enable;
`endif

    missile_width_counter #(.SIZE_BITS(SIZE_BITS)) u_width (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (bus.pixel_tick),
        .start       (start),
        .size        (bus.size),
        .active_next (active_next)
    );

    // Position priority: strobe, then hmove (which swallows a coincident tick), then tick.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            position_q <= '0;
            skip_zero  <= 1'b0;
            value_q    <= 1'b0;
        end else begin
            if (bus.strobe)          position_q <= '0;
            else if (bus.hmove)      position_q <= moved_wrap[POS_BITS-1:0];
            else if (bus.pixel_tick) position_q <= inc_pos;

            if (bus.strobe)                        skip_zero <= 1'b1;
            else if (bus.pixel_tick || bus.hmove)  skip_zero <= 1'b0;

            value_q <= active_next & enable_eff;
        end
    end

    assign bus.value    = value_q;
    assign bus.position = position_q;

endmodule

// File: tb/tb_missile_unit.sv
// Self-checking bench for missile_unit: behavioural line model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_missile_unit;
  import video_pkg::*;

  localparam int LW = 160;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  missile_unit_if #(.POS_BITS(8), .SIZE_BITS(2)) bus();

  missile_unit #(.LINE_WIDTH(LW), .POS_BITS(8), .SIZE_BITS(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model state: position, pixels left in the current draw, strobe-just-happened flag.
  int m_pos;
  int m_rem;
  bit m_skip;
  bit m_val;
  bit m_shadow;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit copy_hit(input int cp, input int p);
    case (cp)
      1:       return p == 0 || p == 16;
      2:       return p == 0 || p == 32;
      3:       return p == 0 || p == 16 || p == 32;
      4:       return p == 0 || p == 64;
      6:       return p == 0 || p == 32 || p == 64;
      default: return p == 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pos = 0; m_rem = 0; m_skip = 0; m_val = 0; m_shadow = 0;
  endtask

  task automatic model_edge();
    bit st;
    bit en_eff;
    en_eff = bus.enable;
`ifdef MISSILE_VDEL_EN
    if (bus.vdel) en_eff = m_shadow;
    if (bus.vdel_load) m_shadow = bus.enable;
`endif
    st = bus.strobe || (bus.pixel_tick && !m_skip && copy_hit(int'(bus.copies), m_pos));
    if (st) m_rem = 1 << bus.size;
    else if (bus.pixel_tick && m_rem > 0) m_rem--;
    m_val = (m_rem > 0) && en_eff;
    if (bus.strobe) m_pos = 0;
    else if (bus.hmove) m_pos = ((m_pos - int'(bus.motion)) % LW + LW) % LW;
    else if (bus.pixel_tick) m_pos = (m_pos + 1) % LW;
    if (bus.strobe) m_skip = 1;
    else if (bus.pixel_tick || bus.hmove) m_skip = 0;
  endtask

  // One clock: inputs were set at the preceding negedge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("value", bus.value, int'(m_val));
    check("position", bus.position, m_pos);
    @(negedge clk);
  endtask

  task automatic strobe_pulse();
    bus.strobe = 1'b1;
    step();
    bus.strobe = 1'b0;
  endtask

  task automatic collect_line(input int cp);
    bus.copies = 3'(cp);
    strobe_pulse();
    for (int i = 0; i < LW; i++) step();
    got_q.delete();
    for (int i = 0; i < LW; i++) begin
      step();
      if (bus.value === 1'b1) got_q.push_back(8'((int'(bus.position) + LW - 1) % LW));
    end
    check("copy_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check("copy_pos", got_q.pop_front(), int'(exp_q.pop_front()));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    reset_n = 1'b0;
    bus.pixel_tick = 0; bus.strobe = 0; bus.hmove = 0; bus.motion = '0;
    bus.size = '0; bus.copies = '0; bus.enable = 0;
`ifdef MISSILE_VDEL_EN
    bus.vdel = 0; bus.vdel_load = 0;
`endif
    model_reset();
    @(negedge clk); @(negedge clk);
    check("reset_value", bus.value, 0);
    check("reset_position", bus.position, 0);
    reset_n = 1'b1;

    // Single copy, size 0: one-pixel pulse, next one a line later.
    bus.pixel_tick = 1; bus.enable = 1;
    strobe_pulse();
    check("strobe_latency", bus.value, 1);
    step();
    check("strobe_one_wide", bus.value, 0);
    n = 1;
    while (bus.value !== 1'b1 && n < 400) begin step(); n++; end
    check("line_gap", n, 161);

    // size 3 keeps 8 pixels even when size changes mid-draw.
    bus.size = 2'd3;
    strobe_pulse();
    len = (bus.value === 1'b1) ? 1 : 0;
    for (int i = 0; i < 3; i++) begin step(); if (bus.value === 1'b1) len++; end
    bus.size = 2'd1;
    while (bus.value === 1'b1 && len < 20) begin step(); if (bus.value === 1'b1) len++; end
    check("size3_width", len, 8);
    n = 0;
    while (bus.value !== 1'b1 && n < 400) begin step(); n++; end
    check("next_line_found", n < 400, 1);
    len = 1;
    while (bus.value === 1'b1 && len < 20) begin step(); if (bus.value === 1'b1) len++; end
    check("size1_width", len, 2);

    // Copy layouts.
    bus.size = 2'd0;
    exp_q = '{8'd0, 8'd32, 8'd64};
    collect_line(6);
    exp_q = '{8'd0, 8'd16, 8'd32};
    collect_line(3);
    bus.copies = 3'd0;

    // HMOVE arithmetic with the pixel tick stopped.
    bus.pixel_tick = 0;
    strobe_pulse();
    bus.pixel_tick = 1;
    for (int i = 0; i < 5; i++) step();
    bus.pixel_tick = 0; bus.hmove = 1; bus.motion = motion_t'(3);
    step();
    check("hmove_5_p3", bus.position, 2);
    bus.hmove = 0;
    strobe_pulse();
    bus.pixel_tick = 1; step(); bus.pixel_tick = 0;
    bus.hmove = 1; bus.motion = motion_t'(3);
    step();
    check("hmove_1_p3", bus.position, 158);
    bus.motion = motion_t'(-8);
    step();
    check("hmove_158_m8", bus.position, 6);
    bus.motion = motion_t'(0);
    step();
    check("hmove_zero", bus.position, 6);
    bus.hmove = 0;

    // strobe dominates a coincident hmove and tick.
    bus.pixel_tick = 1; bus.hmove = 1; bus.motion = motion_t'(5);
    strobe_pulse();
    check("strobe_prio_pos", bus.position, 0);
    check("strobe_prio_val", bus.value, 1);
    bus.hmove = 0;

    // Asynchronous reset in the middle of a wide draw.
    bus.size = 2'd3;
    strobe_pulse(); step(); step();
    check("predraw_value", bus.value, 1);
    reset_n = 1'b0;
    #1;
    check("async_reset_value", bus.value, 0);
    check("async_reset_pos", bus.position, 0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    bus.size = 2'd0;

`ifdef MISSILE_VDEL_EN
    // Delayed enable: shadow is still 0, so nothing is drawn until vdel_load.
    bus.vdel = 1; bus.enable = 1;
    strobe_pulse();
    len = 0;
    for (int i = 0; i < 170; i++) begin step(); if (bus.value === 1'b1) len++; end
    check("vdel_no_load", len, 0);
    bus.vdel_load = 1; step(); bus.vdel_load = 0;
    strobe_pulse();
    check("vdel_loaded", bus.value, 1);
    bus.vdel = 0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.pixel_tick = ($urandom_range(0, 9) < 8);
      bus.strobe     = ($urandom_range(0, 199) == 0);
      bus.hmove      = ($urandom_range(0, 39) == 0);
      bus.motion     = motion_t'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) bus.size   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 79) == 0) bus.copies = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) bus.enable = ~bus.enable;
`ifdef MISSILE_VDEL_EN
      if ($urandom_range(0, 99) == 0) bus.vdel = ~bus.vdel;
      bus.vdel_load = ($urandom_range(0, 59) == 0);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
